seq_multiplier: RTL

- Parametrised iterative shift-add multiplier for the ALU datapath. Handles unsigned and two's-complement operands.
- Uses a start/busy/done handshake: one operand pair is in flight at a time, one partial-product bit is processed per clock, and the product register holds its value until the next operation completes.
- Successor to the fixed 16-bit unsigned multiplier. Adds width generality, signed mode, explicit latency and a registered-result handshake.

---
 rtl/seq_mult_pkg.sv | 37 +++
 rtl/seq_multiplier.sv | 113 +++++++++++
 2 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// Holds the controller state encoding, the operand magnitude helper and
// counter sizing so the datapath module stays free of width arithmetic.
package seq_mult_pkg;

  // Controller states: idle, one bit per clock, final sign fix-up.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Widest operand the magnitude helper can handle.
  localparam int MAX_WIDTH = 64;

  // Operand width used when the instantiating block does not override it.
  localparam int DEFAULT_WIDTH = 16;

  // Counter width needed to index bits 0..w-1 of a w-bit operand.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // Two's-complement magnitude of the low w bits of v. The most negative
  // value maps onto 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [MAX_WIDTH-1:0] mag(input logic [MAX_WIDTH-1:0] v,
                                               input int unsigned w);
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] val;
    logic                 sign;
    mask = (w >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << w) - MAX_WIDTH'(1));
    val  = v & mask;
    sign = |(val & (MAX_WIDTH'(1) << (w - 1)));
    return sign ? ((~val + MAX_WIDTH'(1)) & mask) : val;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, unsigned or two's complement.
// Latency: start sampled at edge E0, done pulses after edge E0+WIDTH+1.
// Flow control: start is ignored while busy; product holds until next done.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;

  logic               signed_eff;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [PW-1:0]      addend;

  // Operand magnitudes and the shifted partial product for the current bit.
  always_comb begin
    signed_eff = signed_mode & SIGNED_EN;
    a_mag      = signed_eff ? WIDTH'(mag(MAX_WIDTH'(a), WIDTH)) : a;
    b_mag      = signed_eff ? WIDTH'(mag(MAX_WIDTH'(b), WIDTH)) : b;
    addend     = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
  end

  // Next-state and datapath updates; every register holds by default.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = signed_eff & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[cnt_q]) begin
          acc_d = acc_q + addend;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        prod_d  = neg_q ? (~acc_q + PW'(1)) : acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that aborts any run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign product = prod_q;

endmodule
